// File: rtl/serial_add_ctrl.sv
// Sequencer for a bit-serial adder: LOAD, WIDTH shift cycles, then a DONE pulse.
// Optional subtract support is enabled with the SERIAL_ADD_CTRL_SUB_EN macro.
module serial_add_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_ADD_CTRL_SUB_EN
  input  logic             sub,
  output logic             cy_set,
  output logic             b_inv,
`endif
  output logic             ld_en,
  output logic             cy_clr,
  output logic             sh_en,
  output logic             cy_en,
  output logic [CNT_W-1:0] bit_idx,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef SERIAL_ADD_CTRL_SUB_EN
  logic sub_q;
  logic accept;

  // sub is only captured on the edge that actually accepts a start
  assign accept = start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sub_q <= 1'b0;
    end else if (accept) begin
      sub_q <= sub;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ld_en     = 1'b0;
    cy_clr    = 1'b0;
    sh_en     = 1'b0;
    cy_en     = 1'b0;
    bit_idx   = '0;
    busy      = 1'b0;
    done      = 1'b0;
`ifdef SERIAL_ADD_CTRL_SUB_EN
    cy_set    = 1'b0;
    b_inv     = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        ld_en     = 1'b1;
        busy      = 1'b1;
`ifdef SERIAL_ADD_CTRL_SUB_EN
        // subtract seeds the carry with 1 to complete the two's complement of B
        cy_clr    = !sub_q;
        cy_set    = sub_q;
`else
        cy_clr    = 1'b1;
`endif
        cnt_nxt   = '0;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        sh_en   = 1'b1;
        cy_en   = 1'b1;
        busy    = 1'b1;
        bit_idx = cnt;
`ifdef SERIAL_ADD_CTRL_SUB_EN
        b_inv   = sub_q;
`endif
        if (cnt == LAST_IDX) begin
          cnt_nxt   = '0;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        done      = 1'b1;
        cnt_nxt   = '0;
        state_nxt = start ? LOAD : IDLE;
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl with a small bit-serial datapath attached.
// Build with SERIAL_ADD_CTRL_SUB_EN defined to also exercise the subtract path.
module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic       clk;
  logic       rst;
  logic       start;
  logic       ld_en, cy_clr, sh_en, cy_en, busy, done;
  logic [2:0] bit_idx;
  logic       cy_set_w, b_inv_w;

  int checks = 0;
  int errors = 0;

`ifdef SERIAL_ADD_CTRL_SUB_EN
  logic sub;
  logic cy_set, b_inv;
  assign cy_set_w = cy_set;
  assign b_inv_w  = b_inv;
`else
  assign cy_set_w = 1'b0;
  assign b_inv_w  = 1'b0;
`endif

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
`ifdef SERIAL_ADD_CTRL_SUB_EN
    .sub     (sub),
    .cy_set  (cy_set),
    .b_inv   (b_inv),
`endif
    .ld_en   (ld_en),
    .cy_clr  (cy_clr),
    .sh_en   (sh_en),
    .cy_en   (cy_en),
    .bit_idx (bit_idx),
    .busy    (busy),
    .done    (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bit-serial datapath driven purely by the controller strobes
  logic [7:0] a_in, b_in;
  logic [7:0] a_sr, b_sr, r_sr;
  logic       cy;
  logic       b_bit, s_bit, c_out;

  assign b_bit = b_sr[0] ^ b_inv_w;
  assign s_bit = a_sr[0] ^ b_bit ^ cy;
  assign c_out = (a_sr[0] & b_bit) | (a_sr[0] & cy) | (b_bit & cy);

  always_ff @(posedge clk) begin
    if (ld_en) begin
      a_sr <= a_in;
      b_sr <= b_in;
    end else if (sh_en) begin
      a_sr <= {1'b0, a_sr[7:1]};
      b_sr <= {1'b0, b_sr[7:1]};
      r_sr <= {s_bit, r_sr[7:1]};
    end
    if (cy_clr)     cy <= 1'b0;
    else if (cy_set_w) cy <= 1'b1;
    else if (cy_en) cy <= c_out;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected field order: cy_set b_inv ld_en cy_clr sh_en cy_en busy done bit_idx[2:0]
  task automatic chk_ctl(input string tag, input bit ld, input bit cc, input bit sh,
                         input bit ce, input bit bs, input bit dn, input int idx,
                         input bit cs, input bit bi);
    logic [2:0]  idx3;
    logic [31:0] obs, exp;
    idx3 = idx[2:0];
    obs  = {21'd0, cy_set_w, b_inv_w, ld_en, cy_clr, sh_en, cy_en, busy, done, bit_idx};
    exp  = {21'd0, cs, bi, ld, cc, sh, ce, bs, dn, idx3};
    chk(tag, obs, exp);
  endtask

  task automatic chk_idle(input string tag);
    chk_ctl(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b0;
    start = 1'b1;
    a_in  = 8'd0;
    b_in  = 8'd0;
`ifdef SERIAL_ADD_CTRL_SUB_EN
    sub   = 1'b1;
`endif

    // Reset held with start high
    repeat (3) begin
      @(negedge clk);
      chk_idle("reset_hold");
    end
    rst   = 1'b1;
    start = 1'b0;
`ifdef SERIAL_ADD_CTRL_SUB_EN
    sub   = 1'b0;
`endif
    repeat (2) begin
      @(negedge clk);
      chk_idle("post_reset_idle");
    end

    // Single add 200 + 100 = 300 -> 44 with carry out
    a_in  = 8'd200;
    b_in  = 8'd100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_ctl("add_load", 1, 1, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      chk_ctl("add_shift", 0, 0, 1, 1, 1, 0, i, 0, 0);
    end
    @(negedge clk);
    chk_ctl("add_done", 0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("add_result", {24'd0, r_sr}, 32'd44);
    chk("add_carry", {31'd0, cy}, 32'd1);
    @(negedge clk);
    chk_idle("add_after_done");

    // Start pulse at bit_idx=3 is ignored
    a_in  = 8'd10;
    b_in  = 8'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_ctl("ign_load", 1, 1, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      chk_ctl("ign_shift", 0, 0, 1, 1, 1, 0, i, 0, 0);
      start = (i == 3);
    end
    @(negedge clk);
    chk_ctl("ign_done", 0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("ign_result", {24'd0, r_sr}, 32'd15);
    @(negedge clk);
    chk_idle("ign_no_second_op");

    // Back-to-back: start held high, LOAD at cycles 1/11/21, done at 10/20/30
    a_in  = 8'd255;
    b_in  = 8'd1;
    start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      chk("b2b_ld_en", {31'd0, ld_en}, {31'd0, (c % 10) == 1});
      chk("b2b_done",  {31'd0, done},  {31'd0, (c % 10) == 0});
      chk("b2b_busy",  {31'd0, busy},  {31'd0, (c % 10) != 0});
    end
    chk("b2b_result", {24'd0, r_sr}, 32'd0);
    chk("b2b_carry", {31'd0, cy}, 32'd1);
    start = 1'b0;
    @(negedge clk);
    chk_idle("b2b_stop");

    // Asynchronous abort at bit_idx=5
    a_in  = 8'd3;
    b_in  = 8'd4;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    chk_ctl("abort_pre", 0, 0, 1, 1, 1, 0, 5, 0, 0);
    rst = 1'b0;
    #1;
    chk_idle("abort_async");
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk_idle("abort_stays_idle");
    end

`ifdef SERIAL_ADD_CTRL_SUB_EN
    // Subtract 20 - 7 = 13
    a_in  = 8'd20;
    b_in  = 8'd7;
    sub   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sub   = 1'b0;
    chk_ctl("sub_load", 1, 0, 0, 0, 1, 0, 0, 1, 0);
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      chk_ctl("sub_shift", 0, 0, 1, 1, 1, 0, i, 0, 1);
    end
    @(negedge clk);
    chk_ctl("sub_done", 0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("sub_result", {24'd0, r_sr}, 32'd13);
    @(negedge clk);
    chk_idle("sub_after_done");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Control unit for the bit-serial adder datapath, which is built from 1-bit registers: two operand shift registers, one result shift register, and a single carry flip-flop. On a `start` pulse it issues these strobes in order: a one-cycle parallel load with carry initialisation, then WIDTH shift/carry-update cycles, then a one-cycle `done`. It holds no data. It only sequences the datapath registers and reports `busy` and `done` to the surrounding controller.

## Interface
Parameters:
- `WIDTH`, default 8: operand width in bits. Legal range is WIDTH ≥ 2.
- `CNT_W`, default `$clog2(WIDTH)`: width of the bit counter. This is a local parameter and is never overridden.

Ports:
- `clk`  in  1  one clock. All state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `start`  in  1  request to begin an addition. Level is sampled on the rising edge.
- `sub`  in  1  subtract request, sampled together with `start`. Present only with `SERIAL_ADD_CTRL_SUB_EN`.
- `ld_en`  out  1  parallel-load strobe for the operand registers.
- `cy_clr`  out  1  forces the carry flip-flop to 0.
- `cy_set`  out  1  forces the carry flip-flop to 1. Present only with the macro.
- `b_inv`  out  1  inverts the B serial bit into the adder. Present only with the macro.
- `sh_en`  out  1  shift enable for the operand and result shift registers.
- `cy_en`  out  1  carry flip-flop capture enable.
- `bit_idx`  out  CNT_W  index of the bit currently being added.
- `busy`  out  1  high in LOAD and SHIFT.
- `done`  out  1  one-cycle completion pulse.

## Operation
- The FSM has four states: IDLE, LOAD, SHIFT, DONE. The state and the counter are registers. All outputs decode from registered state only; there is no combinational path from `start` or `sub` to any output.
- IDLE: all strobes are 0. `start=1` moves to LOAD.
- LOAD (exactly 1 cycle):
  - `ld_en=1`, `busy=1`.
  - `cy_clr=1`, or `cy_set=1` instead when the latched `sub` is 1 (macro build only).
  - Next state is SHIFT and the counter is cleared to 0.
- SHIFT (WIDTH cycles):
  - `sh_en=1`, `cy_en=1`, `busy=1`, `bit_idx` = counter.
  - The counter increments each cycle.
  - When counter == WIDTH-1, the next state is DONE and the counter returns to 0.
- DONE (1 cycle): `done=1`, `busy=0`.
  - `start=1` in DONE goes directly to LOAD (back-to-back operation).
  - Otherwise the next state is IDLE.
- `start` in LOAD or SHIFT is ignored. It is not queued.
- `bit_idx` reads 0 in every state except SHIFT.
- `cy_clr` and `cy_set` are never high in the same cycle. `ld_en` and `sh_en` are never high in the same cycle.

## Timing
- Reset (`rst=0`), asynchronous:
  - State goes to IDLE and the counter to 0.
  - Every output is 0, including `busy`, `done`, `bit_idx`, `cy_set` and `b_inv`.
  - The latched `sub` is cleared to 0.
- A reset mid-operation aborts immediately. After release the block sits in IDLE and needs a new `start`.
- Latency, with `start` sampled high at edge k:
  - `ld_en` is high during cycle k+1.
  - `sh_en` is high during cycles k+2 through k+1+WIDTH.
  - `done` is high during cycle k+2+WIDTH.
- Start-to-done is WIDTH+2 cycles. Back-to-back throughput is one operation per WIDTH+2 cycles.
- A `start` held high continuously restarts from DONE every time. It is never re-accepted during LOAD or SHIFT.
- Counter wrap: the counter never exceeds WIDTH-1. WIDTH need not be a power of two.

## Configuration
- Macro: `SERIAL_ADD_CTRL_SUB_EN`.
- When defined:
  - The `sub`, `cy_set` and `b_inv` ports exist.
  - `sub` is latched into an internal register on the edge where `start` is accepted, in IDLE or DONE.
  - In LOAD, `cy_set` replaces `cy_clr` when the latched value is 1.
  - `b_inv` equals the latched value during SHIFT and is 0 in every other state.
  - Result: A − B in two's complement.
- When undefined:
  - The ports and the register are absent.
  - `cy_clr` is asserted in every LOAD. The block performs addition only.

## Test plan
- Reset: hold `rst=0` with `start=1` for 3 cycles → all outputs 0 and state IDLE. Release → outputs stay 0 until `start` is sampled high.
- Single add, WIDTH=8, one-cycle `start` pulse at edge k → `ld_en`+`cy_clr` in cycle k+1; `sh_en`+`cy_en` for exactly 8 cycles with `bit_idx` 0..7; `done` in cycle k+10; `busy` high for 9 cycles.
- Back-to-back: `start` held high → `done` pulses every 10 cycles. No LOAD is skipped and no extra LOAD occurs.
- Ignored start: a `start` pulse during SHIFT at `bit_idx=3` → the sequence is unchanged and exactly one `done` is produced.
- Mid-operation abort: `rst=0` at `bit_idx=5` → `sh_en`, `busy` and `bit_idx` drop to 0 asynchronously. After release, no `done` until a new `start`.
- Macro build, `sub=1` with `start` → `cy_set=1` and `cy_clr=0` in LOAD; `b_inv=1` throughout SHIFT. With the datapath attached, A=8'd20, B=8'd7 gives result 8'd13. With `sub=0`, A=8'd200, B=8'd100 gives result 8'd44 and the final carry is 1.
